// File: rtl/planificador_llamadas.sv
// planificador_llamadas
// Upstream request scheduler for the elevator controller. Conditions the four
// floor call buttons (2-flop synchroniser + debounce), latches each accepted
// press as a pending request, and picks the next target floor with a
// nearest-first sweep (SCAN) policy.
//
// Floor code: 00 = piso -1, 01 = piso 1, 10 = piso 2, 11 = piso 3.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   llamada[3:0]   in   raw call buttons, bit i = floor code i
//   piso[1:0]      in   current floor from the controller
//   direccion[1:0] in   controller motion: 00 stopped, 01 up, 10 down, 11 = 00
//   llegada        in   one-cycle pulse: doors opened at piso
//   destino[1:0]   out  registered target floor
//   destino_valido out  registered, high while any request is pending
//   pendientes[3:0] out pending-request bitmap
module planificador_llamadas #(
  parameter int DEBOUNCE = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] llamada,
  input  logic [1:0] piso,
  input  logic [1:0] direccion,
  input  logic       llegada,
  output logic [1:0] destino,
  output logic       destino_valido,
  output logic [3:0] pendientes
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic {BAJA = 1'b0, SUBE = 1'b1} sentido_t;

  logic [3:0] sync1, sync2, stable, stable_d, rise;
  logic [3:0] pend_next, clr;
  logic [3:0] sel, above_mask, below_mask, arriba_bits, abajo_bits;
  logic       hay_arriba, hay_abajo;
  logic [1:0] low_above, high_below;
  logic [1:0] destino_next;
  logic       valido_next;
  sentido_t   sentido, sentido_next;

  // Input synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= llamada;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the stable level only follows sync2 after it has
  // disagreed for DEBOUNCE consecutive cycles.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          lvl;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
    assign stable[i] = lvl;
  end

  // Registered copy of the stable level; a 0->1 step yields a single set
  // request, so holding a button never re-requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d <= '0;
    else        stable_d <= stable;
  end
  assign rise = stable & ~stable_d;

  // Clear wins over set on the same bit: the doors are already open there.
  assign clr       = llegada ? (4'b0001 << piso) : 4'b0000;
  assign pend_next = (pendientes | rise) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pendientes <= '0;
    else        pendientes <= pend_next;
  end

  // Floors strictly above / below the current one (shift truncates to 4 bits).
  assign sel         = 4'b0001 << piso;
  assign above_mask  = 4'b1110 << piso;
  assign below_mask  = ~(above_mask | sel);
  assign arriba_bits = pendientes & above_mask;
  assign abajo_bits  = pendientes & below_mask;
  assign hay_arriba  = |arriba_bits;
  assign hay_abajo   = |abajo_bits;

  // State register: sweep direction and registered destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sentido        <= SUBE;
      destino        <= 2'b01;
      destino_valido <= 1'b0;
    end else begin
      sentido        <= sentido_next;
      destino        <= destino_next;
      destino_valido <= valido_next;
    end
  end

  // Next sweep direction. Controller motion dictates it; when stopped, the
  // sweep only reverses if nothing is left ahead but something lies behind.
  always_comb begin
    sentido_next = sentido;
    case (direccion)
      2'b01:   sentido_next = SUBE;
      2'b10:   sentido_next = BAJA;
      default: begin
        if (sentido == SUBE && !hay_arriba && hay_abajo)      sentido_next = BAJA;
        else if (sentido == BAJA && !hay_abajo && hay_arriba) sentido_next = SUBE;
      end
    endcase
  end

  // Nearest pending floor on each side of piso. The descending loop leaves
  // the lowest match above; the ascending loop leaves the highest below.
  always_comb begin
    low_above  = piso;
    high_below = piso;
    for (int f = 3; f >= 0; f--) begin
      if (arriba_bits[f]) low_above = 2'(f);
    end
    for (int f = 0; f < 4; f++) begin
      if (abajo_bits[f]) high_below = 2'(f);
    end
  end

  // Destination select. The direction used is the one being loaded this
  // cycle so a direccion change reaches destino in a single cycle.
  always_comb begin
    destino_next = piso;
    valido_next  = 1'b1;
    if (pendientes == 4'b0000) begin
      valido_next = 1'b0;
    end else if (pendientes[piso]) begin
      destino_next = piso;
    end else if (sentido_next == SUBE) begin
      destino_next = hay_arriba ? low_above : high_below;
    end else begin
      destino_next = hay_abajo ? high_below : low_above;
    end
  end

endmodule

// File: tb/tb_planificador_llamadas.sv
// Bench for planificador_llamadas with DEBOUNCE = 4: directed scenarios from
// the test plan followed by a randomized phase, all checked cycle by cycle
// against a behavioural model of the scheduling rules.
module tb_planificador_llamadas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] llamada;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       llegada;
  logic [1:0] destino;
  logic       destino_valido;
  logic [3:0] pendientes;

  planificador_llamadas #(.DEBOUNCE(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .llamada        (llamada),
    .piso           (piso),
    .direccion      (direccion),
    .llegada        (llegada),
    .destino        (destino),
    .destino_valido (destino_valido),
    .pendientes     (pendientes)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  // Behavioural model state
  logic [3:0] m_pend;
  logic [1:0] m_dest;
  logic       m_valid;
  bit         m_up;
  int         rise_at[4];
  int         btn_left[4];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  // First pending floor met when walking from 'from' in steps of 'step'.
  function automatic int nearest(input logic [3:0] p, input int from, input int step);
    for (int f = from + step; f >= 0 && f <= 3; f += step) begin
      if (p[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = 4'b0000;
    m_dest  = 2'b01;
    m_valid = 1'b0;
    m_up    = 1'b1;
    for (int i = 0; i < 4; i++) rise_at[i] = -100;
  endtask

  // Clean press: the set is expected 2 + DEBOUNCE + 1 = 7 edges later.
  task automatic press(input int i);
    llamada[i] = 1'b1;
    rise_at[i] = ncyc;
  endtask

  task automatic release_btn(input int i);
    llamada[i] = 1'b0;
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic tick();
    logic [3:0] p_next;
    bit         up_next;
    int         above, below, tgt, p, d;
    logic       v_next;
    p       = int'(piso);
    d       = int'(direccion);
    p_next  = m_pend;
    up_next = m_up;
    tgt     = int'(m_dest);
    v_next  = m_valid;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (rise_at[i] + 7 == ncyc + 1) p_next[i] = 1'b1;
      end
      if (llegada) p_next[p] = 1'b0;
      above = nearest(m_pend, p, 1);
      below = nearest(m_pend, p, -1);
      if (d == 1)      up_next = 1'b1;
      else if (d == 2) up_next = 1'b0;
      else if (m_up && above < 0 && below >= 0)  up_next = 1'b0;
      else if (!m_up && below < 0 && above >= 0) up_next = 1'b1;
      v_next = (m_pend != 4'b0000);
      if (m_pend == 4'b0000)  tgt = p;
      else if (m_pend[p])     tgt = p;
      else if (up_next)       tgt = (above >= 0) ? above : below;
      else                    tgt = (below >= 0) ? below : above;
    end
    @(posedge clk);
    ncyc++;
    if (rst_n) begin
      m_pend  = p_next;
      m_up    = up_next;
      m_dest  = 2'(tgt);
      m_valid = v_next;
    end
    #1;
    check("pendientes", pendientes, m_pend);
    check("destino", {2'b00, destino}, {2'b00, m_dest});
    check("destino_valido", {3'b000, destino_valido}, {3'b000, m_valid});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n     = 1'b1;
    llamada   = 4'b0000;
    piso      = 2'b01;
    direccion = 2'b00;
    llegada   = 1'b0;
    model_reset();

    // Power-on reset, asserted asynchronously.
    #2 rst_n = 1'b0;
    #1;
    check("por_pend", pendientes, 4'b0000);
    check("por_dest", {2'b00, destino}, 4'h1);
    check("por_valid", {3'b000, destino_valido}, 4'h0);
    ticks(2);
    rst_n = 1'b1;
    tick();

    // Single call on floor 3.
    press(3);
    ticks(6);
    check("single_pend_c6", pendientes, 4'b0000);
    tick();
    check("single_pend_c7", pendientes, 4'b1000);
    tick();
    check("single_dest_c8", {2'b00, destino}, 4'h3);
    check("single_valid_c8", {3'b000, destino_valido}, 4'h1);
    ticks(4);
    release_btn(3);
    ticks(10);
    press(3);
    ticks(10);
    check("rehold_pend", pendientes, 4'b1000);
    check("rehold_dest", {2'b00, destino}, 4'h3);
    release_btn(3);
    ticks(8);

    // Clear it, then bounce llamada[2].
    piso    = 2'b11;
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    tick();
    llamada[2] = 1'b1; tick(); tick();
    llamada[2] = 1'b0; tick();
    llamada[2] = 1'b1; tick(); tick();
    llamada[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bounce_pend", pendientes, 4'b0000);
      check("bounce_dest", {2'b00, destino}, {2'b00, piso});
    end

    // Sweep order: pending 1001 from floor 1 going up.
    piso      = 2'b01;
    direccion = 2'b01;
    tick();
    direccion = 2'b00;
    press(3);
    press(0);
    ticks(8);
    check("sweep_pend", pendientes, 4'b1001);
    check("sweep_dest_up", {2'b00, destino}, 4'h3);
    piso    = 2'b11;
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    check("sweep_pend_served", pendientes, 4'b0001);
    tick();
    check("sweep_dest_down", {2'b00, destino}, 4'h0);
    release_btn(3);
    release_btn(0);
    ticks(8);

    // Retarget while moving up.
    piso    = 2'b00;
    llegada = 1'b1;
    tick();
    llegada   = 1'b0;
    piso      = 2'b01;
    direccion = 2'b01;
    press(3);
    ticks(8);
    check("retarget_dest_far", {2'b00, destino}, 4'h3);
    press(2);
    ticks(7);
    check("retarget_pend", pendientes, 4'b1100);
    tick();
    check("retarget_dest_near", {2'b00, destino}, 4'h2);
    release_btn(3);
    release_btn(2);
    ticks(8);

    // Simultaneous set/clear on floor 2, plus a set on floor 0.
    piso = 2'b10;
    press(2);
    press(0);
    ticks(6);
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    check("simul_bit2", {3'b000, pendientes[2]}, 4'h0);
    check("simul_bit0", {3'b000, pendientes[0]}, 4'h1);
    tick();
    check("simul_pend", pendientes, 4'b1001);
    check("simul_dest", {2'b00, destino}, 4'h3);

    // Reset mid-operation.
    #2;
    llamada = 4'b0000;
    rst_n   = 1'b0;
    #1;
    check("midrst_pend", pendientes, 4'b0000);
    check("midrst_dest", {2'b00, destino}, 4'h1);
    check("midrst_valid", {3'b000, destino_valido}, 4'h0);
    model_reset();
    piso = 2'b01;
    ticks(3);
    rst_n = 1'b1;
    tick();
    check("postrst_dest", {2'b00, destino}, 4'h1);

    // Randomized phase.
    for (int i = 0; i < 4; i++) btn_left[i] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_left[i] <= 0) begin
          if (llamada[i]) release_btn(i);
          else            press(i);
          btn_left[i] = $urandom_range(8, 20);
        end else begin
          btn_left[i]--;
        end
      end
      if ($urandom_range(0, 7) == 0) piso = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) direccion = 2'($urandom_range(0, 3));
      llegada = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/planificador_llamadas.md
# planificador_llamadas

Upstream request scheduler for the elevator controller. It synchronises and debounces the four floor call buttons, latches them as pending requests, and drives a single target floor (`destino`) using a nearest-first sweep (SCAN) policy. The elevator controller consumes `destino` and returns the current floor, direction and a door-open pulse. That pulse retires the request served at that floor.

## Interface

Floor code, shared with the controller: 00 = piso -1, 01 = piso 1, 10 = piso 2, 11 = piso 3.

**Parameters**
- `DEBOUNCE`, default 500000: cycles an input must be stable before its new level is accepted (10 ms at 50 MHz).

**Ports**
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `llamada`  in  4  raw, asynchronous, active-high buttons; bit i = floor code i.
- `piso`  in  2  current floor, from the controller.
- `direccion`  in  2  controller motion: 00 stopped, 01 up, 10 down; 11 is treated as 00.
- `llegada`  in  1  one-cycle pulse: the controller has opened doors at `piso`.
- `destino`  out  2  selected target floor.
- `destino_valido`  out  1  high while any request is pending.
- `pendientes`  out  4  pending-request bitmap, same bit order as `llamada`.

## Operation

**Input conditioning (per bit)**
- 2-flop synchroniser.
- Debounce counter: counts while the synchronised level differs from the stable level. It clears when the two agree. At count `DEBOUNCE`-1 the stable level flips and the counter clears.
- A stable 0->1 edge produces one set request. Holding the button never re-requests; a new press (release, then press again) is needed.

**Pending register**
- A set request sets `pendientes[i]`.
- `llegada` clears `pendientes[piso]`.
- Set and clear on the same bit in the same cycle: clear wins, because the doors are already opening there.
- Sets on other bits in that same cycle are kept.

**Sweep direction (internal register `sentido`, up or down; reset up)**
- If `direccion` = 01, `sentido` <= up. If `direccion` = 10, `sentido` <= down.
- If `direccion` = 00 and no pending floor lies in `sentido` relative to `piso`, but some pending floor lies the other way, `sentido` flips.

**Destination select (registered), in priority order:**
1. No request pending: `destino` <= `piso`, `destino_valido` <= 0. This keeps the controller stationary.
2. `pendientes[piso]` = 1: `destino` <= `piso`.
3. `sentido` up: `destino` <= lowest pending floor above `piso`; if there is none, the highest pending floor below.
4. `sentido` down: `destino` <= highest pending floor below `piso`; if there is none, the lowest pending floor above.
- `destino_valido` <= 1 in cases 2–4.
- A new call between `piso` and the current target, in the travel direction, retargets to that nearer floor. This is intended behaviour.
- All comparisons are unsigned on the 2-bit code; the code order equals the physical order.

## Timing

- **Reset (async, immediate):** `pendientes` = 0000, `destino` = 01 (the controller's reset floor), `destino_valido` = 0, `sentido` = up, all synchroniser/debounce state = 0.
- **Reset mid-operation:** all pending requests are lost. After release, `destino` follows `piso` from the first edge.
- **Press to pending:** 2 (sync) + `DEBOUNCE` + 1 cycles from the button level change to `pendientes[i]` = 1.
- **Pending/`piso`/`direccion` change to `destino`:** 1 cycle.
- **`llegada` to bit clear:** next edge. `destino` updates one cycle after that.
- `destino` changes only on `clk` edges and never glitches. The controller may sample it at any edge.

## Test plan

Simulation uses `DEBOUNCE` = 4.

- **Reset mid-operation:** `pendientes` = 1001, `destino` = 11; pulse `rst_n` low for 3 cycles asynchronously. -> Outputs go immediately to 0000 / 01 / 0. After release with `piso` = 01, `destino` = 01.
- **Single call:** `piso` = 01, `direccion` = 00; hold `llamada[3]` high 12 cycles. -> `pendientes` = 1000 at cycle 7 after the rise; `destino` = 11, `destino_valido` = 1 at cycle 8. Releasing and re-holding the button without `llegada` changes nothing.
- **Bounce rejection:** `llamada[2]` high for 2 cycles, low for 1, high for 2, then low. -> `pendientes` stays 0000 and `destino` = `piso` throughout.
- **Sweep order:** `pendientes` = 1001, `piso` = 01, `sentido` up. -> `destino` = 11. Then `piso` = 11 with `llegada` pulse -> `pendientes` = 0001, `sentido` flips to down, `destino` = 00.
- **Retarget:** moving up (`direccion` = 01, `piso` = 01, `destino` = 11); debounced call on floor 10. -> `destino` = 10 one cycle after `pendientes` = 1100.
- **Simultaneous set/clear:** `llegada` pulse at `piso` = 10 in the same cycle as the debounced edge of `llamada[2]`, with bit 0 also setting. -> `pendientes[2]` = 0, `pendientes[0]` = 1.
